// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// sequencer states and the LO fill pattern used on divide-by-zero.
package hilo_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_MULU = 2'b10,
    OP_DIVU = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  localparam logic DBZ_LO_FILL_BIT = 1'b1;

  function automatic logic op_is_div(input op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_t o);
    return (o == OP_MUL) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_iter_step.sv
// One combinational iteration on the {acc, q} pair: a shift-add multiply
// step or a restoring-divide step, chosen by is_div.
module hilo_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Divide keeps the remainder below the divisor, so the W-bit difference is exact whenever it is taken.
  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shifted = {acc, q[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - m;
    if (is_div) begin
      if (shifted >= {1'b0, m}) begin
        acc_next = diff;
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = sum[WIDTH:1];
      q_next   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit producing the HI/LO pair for mfhi/mflo.
// Optional mthi/mtlo write ports are enabled with HILO_MTHI_MTLO_EN.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef HILO_MTHI_MTLO_EN
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    count;
  logic             sign_a;
  logic             sign_b;
  logic             zero_div;

  op_t              op_in;
  logic             in_signed;
  logic             in_div;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] q_next;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  always_comb begin
    op_in     = op_t'(op);
    in_signed = op_is_signed(op_in);
    in_div    = op_is_div(op_in);
    mag_a     = (in_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (in_signed && b[WIDTH-1]) ? -b : b;
  end

  hilo_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_is_div(op_q)),
    .acc      (acc_q),
    .q        (q_q),
    .m        (m_q),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  // On divide-by-zero the original dividend was parked in acc, so hi simply copies it.
  always_comb begin
    prod     = {acc_q, q_q};
    prod_fix = (op_q == OP_MUL && (sign_a ^ sign_b)) ? -prod : prod;
    if (zero_div) begin
      hi_fix = acc_q;
      lo_fix = {WIDTH{DBZ_LO_FILL_BIT}};
    end else if (op_is_div(op_q)) begin
      hi_fix = (op_q == OP_DIV && sign_a) ? -acc_q : acc_q;
      lo_fix = (op_q == OP_DIV && (sign_a ^ sign_b)) ? -q_q : q_q;
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      op_q        <= OP_MUL;
      acc_q       <= '0;
      q_q         <= '0;
      m_q         <= '0;
      count       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      zero_div    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
`ifdef HILO_MTHI_MTLO_EN
          if (hi_wr) hi <= wr_data;
          if (lo_wr) lo <= wr_data;
`endif
          if (start) begin
            op_q        <= op_in;
            sign_a      <= in_signed && a[WIDTH-1];
            sign_b      <= in_signed && b[WIDTH-1];
            count       <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            zero_div    <= in_div && (b == '0);
            acc_q       <= (in_div && (b == '0)) ? a : '0;
            m_q         <= in_div ? mag_b : mag_a;
            q_q         <= in_div ? mag_a : mag_b;
            state       <= (in_div && (b == '0)) ? FIX : RUN;
          end
        end
        RUN: begin
          acc_q <= acc_next;
          q_q   <= q_next;
          count <= count + 1'b1;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          hi          <= hi_fix;
          lo          <= lo_fix;
          div_by_zero <= zero_div;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: a cycle-level arithmetic model plus
// directed literal checks; mthi/mtlo checks are built with HILO_MTHI_MTLO_EN.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef HILO_MTHI_MTLO_EN
  logic         hi_wr;
  logic         lo_wr;
  logic [W-1:0] wr_data;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  bit check_en = 1'b0;

  always #5 clock = ~clock;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
`ifdef HILO_MTHI_MTLO_EN
    .hi_wr       (hi_wr),
    .lo_wr       (lo_wr),
    .wr_data     (wr_data),
`endif
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one operation, straight from 64-bit arithmetic.
  function automatic void refModel(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    logic signed [2*W-1:0] sx, sy, sp;
    logic [2*W-1:0] up;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'b00: begin sp = sx * sy; h = sp[2*W-1:W]; l = sp[W-1:0]; end
      2'b10: begin up = {{W{1'b0}}, x} * {{W{1'b0}}, y}; h = up[2*W-1:W]; l = up[W-1:0]; end
      2'b01: begin
        if (y == '0) begin z = 1'b1; h = x; l = '1; end
        else begin sp = sx / sy; l = sp[W-1:0]; sp = sx % sy; h = sp[W-1:0]; end
      end
      default: begin
        if (y == '0) begin z = 1'b1; h = x; l = '1; end
        else begin l = x / y; h = x % y; end
      end
    endcase
  endfunction

  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_dbz  = 1'b0;
  logic [W-1:0] m_hi   = '0;
  logic [W-1:0] m_lo   = '0;
  logic [W-1:0] p_hi, p_lo;
  logic         p_dbz;
  int           m_left = 0;

  // Model: an accepted start schedules its result W+1 edges later (1 on divide-by-zero).
  always @(posedge clock) begin
    if (clear) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
      end
    end else begin
`ifdef HILO_MTHI_MTLO_EN
      if (hi_wr) m_hi = wr_data;
      if (lo_wr) m_lo = wr_data;
`endif
      if (start) begin
        refModel(op, a, b, p_hi, p_lo, p_dbz);
        m_left = p_dbz ? 1 : W + 1;
        m_busy = 1'b1;
        m_dbz  = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("busy", 64'(busy), 64'(m_busy));
      checkOutput("done", 64'(done), 64'(m_done));
      checkOutput("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
      checkOutput("hi", 64'(hi), 64'(m_hi));
      checkOutput("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  // Counts edges from the accepting edge (inclusive) to the edge that raised done.
  task automatic waitDone(output int edges);
    edges = 1;
    while (!done && edges < 200) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    if (!done) checkOutput("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic runOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    logic [W-1:0] eh, el;
    logic ez;
    int edges;
    refModel(o, x, y, eh, el, ez);
    applyStimulus(o, x, y);
    waitDone(edges);
    checkOutput({tag, "_latency"}, 64'(edges), ez ? 64'd2 : 64'(W + 2));
  endtask

  initial begin
    int edges;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    clear = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
`ifdef HILO_MTHI_MTLO_EN
    hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
`endif
    repeat (2) @(negedge clock);
    check_en = 1'b1;
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    clear = 1'b0;

    runOp(2'b00, 32'd7, -32'sd3, "mul");
    checkOutput("mul_hi", 64'(hi), 64'hFFFFFFFF);
    checkOutput("mul_lo", 64'(lo), 64'hFFFFFFEB);

    runOp(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulu");
    checkOutput("mulu_hi", 64'(hi), 64'hFFFFFFFE);
    checkOutput("mulu_lo", 64'(lo), 64'h00000001);

    runOp(2'b01, -32'sd7, 32'd2, "div");
    checkOutput("div_lo", 64'(lo), 64'hFFFFFFFD);
    checkOutput("div_hi", 64'(hi), 64'hFFFFFFFF);

    runOp(2'b01, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    checkOutput("div_ovf_lo", 64'(lo), 64'h80000000);
    checkOutput("div_ovf_hi", 64'(hi), 64'h0);
    checkOutput("div_ovf_dbz", 64'(div_by_zero), 64'h0);

    runOp(2'b11, 32'd5, 32'd0, "dbz");
    checkOutput("dbz_hi", 64'(hi), 64'h5);
    checkOutput("dbz_lo", 64'(lo), 64'hFFFFFFFF);
    checkOutput("dbz_flag", 64'(div_by_zero), 64'h1);

    runOp(2'b00, 32'd2, 32'd2, "mul2");
    checkOutput("mul2_dbz", 64'(div_by_zero), 64'h0);
    checkOutput("mul2_hi", 64'(hi), 64'h0);
    checkOutput("mul2_lo", 64'(lo), 64'h4);

    // Clear in the middle of a multiply after a known result.
    runOp(2'b10, 32'h80000001, 32'd2, "pre_clear");
    checkOutput("pre_clear_hi", 64'(hi), 64'h1);
    checkOutput("pre_clear_lo", 64'(lo), 64'h2);
    applyStimulus(2'b00, 32'd3, 32'd5);
    repeat (10) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    checkOutput("clear_hi", 64'(hi), 64'h0);
    checkOutput("clear_lo", 64'(lo), 64'h0);
    checkOutput("clear_busy", 64'(busy), 64'h0);
    checkOutput("clear_done", 64'(done), 64'h0);
    clear = 1'b0;
    repeat (3) @(negedge clock);

    // A start pulse mid-run must not disturb the operation in flight.
    applyStimulus(2'b01, -32'sd100, 32'd7);
    repeat (5) @(negedge clock);
    start = 1'b1; op = 2'b10; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clock);
    start = 1'b0;
    waitDone(edges);
    checkOutput("midrun_lo", 64'(lo), 64'hFFFFFFF2);
    checkOutput("midrun_hi", 64'(hi), 64'hFFFFFFFE);

`ifdef HILO_MTHI_MTLO_EN
    @(negedge clock);
    @(negedge clock);
    ra = lo;
    hi_wr = 1'b1; wr_data = 32'h1234;
    @(negedge clock);
    hi_wr = 1'b0;
    checkOutput("mthi_hi", 64'(hi), 64'h1234);
    checkOutput("mthi_lo", 64'(lo), 64'(ra));
    applyStimulus(2'b10, 32'd3, 32'd3);
    hi_wr = 1'b1; wr_data = 32'h5678;
    @(negedge clock);
    hi_wr = 1'b0;
    checkOutput("mthi_busy_hi", 64'(hi), 64'h1234);
    waitDone(edges);
`endif

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clock);
      runOp(ro, ra, rb, "rand");
    end

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that produces the HI/LO register pair read by the mfhi/mflo instructions.
- Sits upstream of the Z-mux path used by mfhi/mflo: hi/lo outputs are held stable and feed the ZSelect HI/LO inputs of the datapath.
- The control sequencer pulses start with the operands from the Y/bus path, then stalls until done.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  00 MUL signed, 01 DIV signed, 10 MULU, 11 DIVU.
- a  in  WIDTH  multiplicand / dividend; captured when start is accepted.
- b  in  WIDTH  multiplier / divisor; captured when start is accepted.
- busy  out  1  operation in progress (RUN or FIX).
- done  out  1  single-cycle pulse; hi/lo are valid and updated.
- div_by_zero  out  1  valid with done; set on a DIV/DIVU with b==0.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.

Behaviour:
- Reset (clear=1 at a rising edge): state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0, iteration counter=0. clear overrides every other input, including in mid-operation; no partial result is written.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE: on the edge where start=1, latch op, a and b, take operand magnitudes (signed ops), set count=0, and go to RUN. start=0 keeps the unit in IDLE.
- RUN: one iteration per cycle. MUL uses shift-add on magnitudes over a 2*WIDTH accumulator. DIV uses restoring divide on magnitudes. After WIDTH iterations (count==WIDTH-1), go to FIX.
- FIX: apply sign correction.
  - Product is negated if sign(a)^sign(b), signed MUL only.
  - Quotient is negated if sign(a)^sign(b); remainder takes the sign of a (signed DIV only). Quotient truncates toward zero.
  - Write hi/lo, go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. start is ignored in DONE.
- Latency: start sampled at edge E0. busy is high after E0 through E(WIDTH+1). hi/lo update at E(WIDTH+1). done is high in the cycle after that edge. Total = WIDTH+2 edges (34 at WIDTH=32).
- Divide by zero (DIV/DIVU with b==0): detected at E0.
  - Go directly to FIX, skipping RUN.
  - FIX writes hi=a and lo={WIDTH{1}} and sets div_by_zero.
  - Latency is 2 edges.
- Overflow case -2^31 / -1 (signed DIV): lo=0x80000000, hi=0, div_by_zero=0.
- start while busy or in DONE: ignored; it does not queue.
- hi/lo hold their last value in all states except the FIX write edge. mfhi/mflo may read them at any time; during busy they read the previous result.
- div_by_zero holds until the next accepted start, which clears it.

Optional Feature:
- Macro: HILO_MTHI_MTLO_EN.
- When defined, the block adds ports hi_wr (in 1), lo_wr (in 1) and wr_data (in WIDTH) for mthi/mtlo.
  - In IDLE, hi_wr loads hi=wr_data and lo_wr loads lo=wr_data on the next edge. Both may be asserted in the same cycle.
  - If start and a write arrive in the same cycle, the write occurs and start is still accepted.
  - Writes during busy or DONE are ignored.
- When not defined, the ports are absent and hi/lo are written only by FIX.

Decomposition:
- Package hilo_pkg holds:
  - op encodings: OP_MUL, OP_DIV, OP_MULU, OP_DIVU;
  - state enum: IDLE, RUN, FIX, DONE;
  - constant for the divide-by-zero LO fill value.
- Sub-module hilo_iter_step is purely combinational: one shift-add or restore-subtract iteration on {acc, q}. The FSM, counter and sign logic stay in the top module.

Test Plan:
- MUL a=7, b=-3 -> done at edge 34 after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 -> done 2 edges after start; hi=5, lo=0xFFFFFFFF, div_by_zero=1. A following MUL 2*2 clears div_by_zero, giving hi=0, lo=4.
- Assert clear at RUN iteration 10 of a MUL following a previous result hi=1, lo=2 -> next edge: IDLE, hi=0, lo=0, busy=0, no done pulse. start pulsed mid-RUN of another op -> ignored, result unchanged.
- With HILO_MTHI_MTLO_EN: hi_wr=1, wr_data=0x1234 in IDLE -> hi=0x1234, lo unchanged. The same write during busy -> hi unchanged.
